iob_uut_csr: RTL and testbench

Memory-mapped control/status register block with an IOb native subordinate interface, instantiated as `iob_uut`. A host reaches it through a 32-bit native bus for word or sub-word register accesses. It holds two scratch registers, a hardware adder result, and a gated cycle counter. It is the unit under test for the file-IPC host-driven simulation flow.

---
 rtl/iob_uut_pkg.sv | 42 ++++
 rtl/iob_uut_counter.sv | 32 +++
 rtl/iob_uut_csr.sv | 106 ++++++++++
 tb/tb_iob_uut_csr.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/iob_uut_pkg.sv
// Shared constants for the iob_uut CSR block: register byte offsets,
// identification word, CTRL bit positions and reset values.
package iob_uut_pkg;

   localparam int unsigned DATA_W = 32;

   // Register byte offsets
   localparam logic [4:0] ADDR_ID       = 5'h00;
   localparam logic [4:0] ADDR_SCRATCH0 = 5'h04;
   localparam logic [4:0] ADDR_SCRATCH1 = 5'h08;
   localparam logic [4:0] ADDR_CTRL     = 5'h0C;
   localparam logic [4:0] ADDR_COUNT    = 5'h10;
   localparam logic [4:0] ADDR_SUM      = 5'h14;
   localparam logic [4:0] ADDR_STATUS   = 5'h18;
   localparam logic [4:0] ADDR_RSVD     = 5'h1C;

   // Identification constant returned by the ID register
   localparam logic [31:0] ID_VALUE = 32'h10B0_0001;

   // CTRL bit positions
   localparam int unsigned CTRL_EN_BIT  = 0;
   localparam int unsigned CTRL_CLR_BIT = 1;

   // Reset values
   localparam logic [31:0] SCRATCH_RST = 32'h0000_0000;
   localparam logic        CTRL_EN_RST = 1'b0;
   localparam logic [31:0] COUNT_RST   = 32'h0000_0000;
   localparam logic [31:0] RDATA_RST   = 32'h0000_0000;

   // Replace only the byte lanes selected by strb
   function automatic logic [31:0] wstrb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/iob_uut_counter.sv
// 32-bit free-running counter with enable, synchronous clear and clock
// enable. Clear has priority over enable; wraps naturally at 2^32.
module iob_uut_counter
   import iob_uut_pkg::*;
(
   input  logic        clk_i,
   input  logic        arst_n_i,
   input  logic        cke_i,
   input  logic        en_i,
   input  logic        clr_i,
   output logic [31:0] count_o
);

   logic [31:0] count_q;
   logic [31:0] count_d;

   // Next count: clear wins, otherwise increment while enabled
   always_comb begin
      count_d = count_q;
      if (clr_i)     count_d = COUNT_RST;
      else if (en_i) count_d = count_q + 32'd1;
   end

   // Count register, frozen while the clock enable is low
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i)  count_q <= COUNT_RST;
      else if (cke_i) count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/iob_uut_csr.sv
// CSR block behind an IOb native subordinate port: address decode,
// byte-strobed scratch/control registers, adder, and registered read path.
module iob_uut_csr
   import iob_uut_pkg::*;
#(
   parameter int IOB_CSRS_ADDR_W = 5
) (
   input  logic                       clk_i,
   input  logic                       arst_n_i,
   input  logic                       cke_i,
   input  logic                       iob_valid_i,
   input  logic [IOB_CSRS_ADDR_W-1:0] iob_addr_i,
   input  logic [31:0]                iob_wdata_i,
   input  logic [3:0]                 iob_wstrb_i,
   output logic                       iob_rvalid_o,
   output logic [31:0]                iob_rdata_o,
   output logic                       iob_ready_o
);

   localparam int WIDX_W = IOB_CSRS_ADDR_W - 2;

   logic [WIDX_W-1:0] widx;
   logic              req_acc;
   logic              wr_acc;
   logic              rd_acc;

   logic [31:0] scratch0_q, scratch0_d;
   logic [31:0] scratch1_q, scratch1_d;
   logic        ctrl_en_q, ctrl_en_d;
   logic        ctrl_clr;
   logic        rvalid_q;
   logic [31:0] rdata_q;
   logic [31:0] rd_mux;
   logic [31:0] count;
   logic [32:0] sum_full;

   // Ready is held low during reset so nothing is accepted
   assign iob_ready_o = cke_i & arst_n_i;
   assign req_acc     = iob_valid_i & iob_ready_o;
   assign wr_acc      = req_acc & (|iob_wstrb_i);
   assign rd_acc      = req_acc & ~(|iob_wstrb_i);
   assign widx        = iob_addr_i[IOB_CSRS_ADDR_W-1:2];

   // Adder over the registered scratch values; bit 32 is the carry
   assign sum_full = {1'b0, scratch0_q} + {1'b0, scratch1_q};

   // Write decode with per-byte strobe merge; CLR is a one-shot pulse
   always_comb begin
      scratch0_d = scratch0_q;
      scratch1_d = scratch1_q;
      ctrl_en_d  = ctrl_en_q;
      ctrl_clr   = 1'b0;
      if (wr_acc) begin
         if (widx == WIDX_W'(ADDR_SCRATCH0 >> 2))
            scratch0_d = wstrb_merge(scratch0_q, iob_wdata_i, iob_wstrb_i);
         if (widx == WIDX_W'(ADDR_SCRATCH1 >> 2))
            scratch1_d = wstrb_merge(scratch1_q, iob_wdata_i, iob_wstrb_i);
         if ((widx == WIDX_W'(ADDR_CTRL >> 2)) && iob_wstrb_i[0]) begin
            ctrl_en_d = iob_wdata_i[CTRL_EN_BIT];
            ctrl_clr  = iob_wdata_i[CTRL_CLR_BIT];
         end
      end
   end

   // Read mux; unmapped and reserved words return zero
   always_comb begin
      rd_mux = 32'h0;
      if (widx == WIDX_W'(ADDR_ID >> 2))       rd_mux = ID_VALUE;
      if (widx == WIDX_W'(ADDR_SCRATCH0 >> 2)) rd_mux = scratch0_q;
      if (widx == WIDX_W'(ADDR_SCRATCH1 >> 2)) rd_mux = scratch1_q;
      if (widx == WIDX_W'(ADDR_CTRL >> 2))     rd_mux[CTRL_EN_BIT] = ctrl_en_q;
      if (widx == WIDX_W'(ADDR_COUNT >> 2))    rd_mux = count;
      if (widx == WIDX_W'(ADDR_SUM >> 2))      rd_mux = sum_full[31:0];
      if (widx == WIDX_W'(ADDR_STATUS >> 2))   rd_mux[0] = sum_full[32];
   end

   // Register state and read response; everything holds while cke is low
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         scratch0_q <= SCRATCH_RST;
         scratch1_q <= SCRATCH_RST;
         ctrl_en_q  <= CTRL_EN_RST;
         rvalid_q   <= 1'b0;
         rdata_q    <= RDATA_RST;
      end else if (cke_i) begin
         scratch0_q <= scratch0_d;
         scratch1_q <= scratch1_d;
         ctrl_en_q  <= ctrl_en_d;
         rvalid_q   <= rd_acc;
         if (rd_acc) rdata_q <= rd_mux;
      end
   end

   iob_uut_counter u_counter (
      .clk_i    (clk_i),
      .arst_n_i (arst_n_i),
      .cke_i    (cke_i),
      .en_i     (ctrl_en_q),
      .clr_i    (ctrl_clr),
      .count_o  (count)
   );

   assign iob_rvalid_o = rvalid_q;
   assign iob_rdata_o  = rdata_q;

endmodule

// File: tb/tb_iob_uut_csr.sv
// Directed bench for iob_uut_csr: bus reads/writes with hand-computed values.
module tb_iob_uut_csr;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        cke;
   logic        valid;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        rvalid;
   logic [31:0] rdata;
   logic        ready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   iob_uut_csr #(.IOB_CSRS_ADDR_W(5)) dut (
      .clk_i        (clk),
      .arst_n_i     (arst_n),
      .cke_i        (cke),
      .iob_valid_i  (valid),
      .iob_addr_i   (addr),
      .iob_wdata_i  (wdata),
      .iob_wstrb_i  (wstrb),
      .iob_rvalid_o (rvalid),
      .iob_rdata_o  (rdata),
      .iob_ready_o  (ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: drive for one cycle, return at the next negedge
   task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      valid = 1'b1; addr = a; wdata = d; wstrb = s;
      @(negedge clk);
      valid = 1'b0; wstrb = 4'h0;
      $display("write addr=%02h data=%08h strb=%b", a, d, s);
   endtask

   task automatic bus_read(input string tag, input logic [4:0] a, input logic [31:0] exp);
      valid = 1'b1; addr = a; wstrb = 4'h0;
      @(negedge clk);
      valid = 1'b0;
      $display("read  addr=%02h rvalid=%0b data=%08h", a, rvalid, rdata);
      check({tag, "_rvalid"}, {31'b0, rvalid}, 32'd1);
      check(tag, rdata, exp);
   endtask

   initial begin
      arst_n = 1'b0; cke = 1'b1; valid = 1'b0;
      addr = '0; wdata = '0; wstrb = '0;

      // Reset state
      #12;
      check("rst_ready", {31'b0, ready}, 32'd0);
      check("rst_rvalid", {31'b0, rvalid}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      @(negedge clk);
      arst_n = 1'b1;

      // ID read, one-cycle rvalid pulse, reserved read
      bus_read("id", 5'h00, 32'h10B0_0001);
      @(negedge clk);
      check("rvalid_pulse", {31'b0, rvalid}, 32'd0);
      check("rdata_hold", rdata, 32'h10B0_0001);
      bus_read("rsvd", 5'h1C, 32'h0);

      // Adder with carry
      bus_write(5'h04, 32'hFFFF_FFFF, 4'hF);
      bus_write(5'h08, 32'h0000_0002, 4'hF);
      bus_read("sum", 5'h14, 32'h0000_0001);
      bus_read("carry", 5'h18, 32'h0000_0001);
      bus_read("scr1", 5'h08, 32'h0000_0002);

      // Byte-strobed write
      bus_write(5'h04, 32'h1122_3344, 4'hF);
      bus_write(5'h04, 32'h00AB_0000, 4'b0100);
      bus_read("strb", 5'h04, 32'h11AB_3344);
      bus_read("sum2", 5'h14, 32'h11AB_3346);
      bus_read("nocarry", 5'h18, 32'h0);

      // Counter: enable, 10 idle cycles -> 10 enabled edges before the read
      bus_write(5'h0C, 32'h1, 4'h1);
      repeat (10) @(negedge clk);
      bus_read("count10", 5'h10, 32'd10);
      // Clear while staying enabled: read samples 0, then 1
      bus_write(5'h0C, 32'h3, 4'h1);
      bus_read("count_clr", 5'h10, 32'd0);
      bus_read("count_one", 5'h10, 32'd1);
      // Clock enable low for 5 cycles: counter and response hold
      cke = 1'b0;
      #1;
      check("cke_ready", {31'b0, ready}, 32'd0);
      repeat (5) @(negedge clk);
      check("cke_rvalid_hold", {31'b0, rvalid}, 32'd1);
      check("cke_rdata_hold", rdata, 32'd1);
      cke = 1'b1;
      bus_read("count_frozen", 5'h10, 32'd2);
      // Clear and disable
      bus_write(5'h0C, 32'h2, 4'h1);
      bus_read("ctrl", 5'h0C, 32'h0);
      bus_read("count_off", 5'h10, 32'd0);

      // Write to RO ID is accepted and ignored
      valid = 1'b1; addr = 5'h00; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
      #1;
      check("ro_ready", {31'b0, ready}, 32'd1);
      @(negedge clk);
      valid = 1'b0; wstrb = 4'h0;
      $display("write addr=00 data=deadbeef strb=1111");
      bus_read("id_ro", 5'h00, 32'h10B0_0001);
      bus_write(5'h1C, 32'hFFFF_FFFF, 4'hF);
      bus_read("rsvd_wr", 5'h1C, 32'h0);

      // Reset in the cycle after a read is accepted
      valid = 1'b1; addr = 5'h04; wstrb = 4'h0;
      @(posedge clk);
      #2 arst_n = 1'b0;
      #1;
      valid = 1'b0;
      $display("reset asserted after read accept rvalid=%0b", rvalid);
      check("mid_rst_rvalid", {31'b0, rvalid}, 32'd0);
      check("mid_rst_ready", {31'b0, ready}, 32'd0);
      check("mid_rst_rdata", rdata, 32'd0);
      repeat (2) @(negedge clk);
      check("rst_held_rvalid", {31'b0, rvalid}, 32'd0);
      arst_n = 1'b1;
      bus_read("scr0_rst", 5'h04, 32'h0);
      bus_read("scr1_rst", 5'h08, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety bound so the run always terminates
   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
